// File: rtl/bf16_pkg.sv
// bf16_pkg: shared widths and opcodes for the bf16 arbiter slice
package bf16_pkg;
    localparam int BF16_W = 16;
    localparam int OPC_W  = 3;
    typedef logic [OPC_W-1:0] opc_t;
    localparam opc_t OPC_ADD = 3'b000;
    localparam opc_t OPC_SUB = 3'b001;
    localparam opc_t OPC_MUL = 3'b010;
    localparam opc_t OPC_MAX = OPC_MUL;
    localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7fc0;
endpackage

// File: rtl/bf16_unit.sv
// BF16Unit: combinational bf16 add/sub/mul, round-to-nearest-even
// Subnormal inputs and results flush to zero; any inf/NaN input yields a quiet NaN.
module BF16Unit
    import bf16_pkg::*;
(
    input  logic [OPC_W-1:0]  io_opc,
    input  logic [BF16_W-1:0] io_a,
    input  logic [BF16_W-1:0] io_b,
    output logic [BF16_W-1:0] io_y
);
    logic [7:0]        w_ea, w_eb, w_el, w_es, w_d, w_dd;
    logic [7:0]        w_ma, w_mb, w_ml, w_ms;
    logic              w_sa, w_sb, w_sl, w_swap, w_eff_sub, w_special;
    logic [33:0]       w_shf;
    logic [18:0]       w_x, w_y, w_r, w_n;
    logic [4:0]        w_p;
    logic [15:0]       w_prod;
    logic              w_zero, w_s, w_g, w_st;
    logic signed [9:0] w_e, w_ef;
    logic [6:0]        w_m;
    logic [8:0]        w_rnd;

    always_comb begin
        w_ea      = io_a[14:7];
        w_eb      = io_b[14:7];
        w_ma      = (w_ea == 8'd0) ? 8'd0 : {1'b1, io_a[6:0]};
        w_mb      = (w_eb == 8'd0) ? 8'd0 : {1'b1, io_b[6:0]};
        w_sa      = io_a[15];
        w_sb      = io_b[15] ^ (io_opc == OPC_SUB);
        w_swap    = {w_eb, w_mb} > {w_ea, w_ma};
        w_el      = w_swap ? w_eb : w_ea;
        w_es      = w_swap ? w_ea : w_eb;
        w_ml      = w_swap ? w_mb : w_ma;
        w_ms      = w_swap ? w_ma : w_mb;
        w_sl      = w_swap ? w_sb : w_sa;
        w_eff_sub = w_sa ^ w_sb;
        w_d       = w_el - w_es;
        w_dd      = (w_d > 8'd26) ? 8'd26 : w_d;
        // bits shifted past the guard field collapse into a single sticky LSB
        w_shf     = {w_ms, 26'b0} >> w_dd;
        w_x       = {1'b0, w_ml, 10'b0};
        w_y       = {1'b0, w_shf[33:17], |w_shf[16:0]};
        w_r       = w_eff_sub ? w_x - w_y : w_x + w_y;
        w_p       = 5'd0;
        for (int i = 0; i < 19; i++)
            if (w_r[i]) w_p = 5'(i);
        w_n       = w_r << (5'd18 - w_p);
        w_prod    = 16'(w_ma) * 16'(w_mb);
        if (io_opc == OPC_MUL) begin
            w_s    = io_a[15] ^ io_b[15];
            w_zero = (w_ea == 8'd0) | (w_eb == 8'd0);
            w_e    = $signed({2'b0, w_ea}) + $signed({2'b0, w_eb}) - 10'sd127 + $signed({9'b0, w_prod[15]});
            w_m    = w_prod[15] ? w_prod[14:8] : w_prod[13:7];
            w_g    = w_prod[15] ? w_prod[7] : w_prod[6];
            w_st   = w_prod[15] ? |w_prod[6:0] : |w_prod[5:0];
        end else begin
            w_s    = w_sl;
            w_zero = ~w_n[18];
            w_e    = $signed({2'b0, w_el}) + $signed({5'b0, w_p}) - 10'sd17;
            w_m    = w_n[17:11];
            w_g    = w_n[10];
            w_st   = |w_n[9:0];
        end
        w_rnd     = {2'b01, w_m} + {8'b0, w_g & (w_st | w_m[0])};
        w_ef      = w_e + $signed({9'b0, w_rnd[8]});
        w_special = (w_ea == 8'hff) | (w_eb == 8'hff);
        io_y      = w_special ? BF16_QNAN :
                    w_zero ? 16'h0000 :
                    (w_ef >= 10'sd255) ? {w_s, 8'hff, 7'h00} :
                    (w_ef <= 10'sd0) ? 16'h0000 :
                    {w_s, w_ef[7:0], w_rnd[6:0]};
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; search starts one past the last winner
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    logic [IW-1:0] r_ptr, w_cand;
    logic          w_hit;

    always_comb begin
        o_gnt  = '0;
        o_idx  = r_ptr;
        w_hit  = 1'b0;
        w_cand = r_ptr;
        for (int k = 1; k <= N; k++) begin
            w_cand = (int'(r_ptr) + k >= N) ? IW'(int'(r_ptr) + k - N) : IW'(int'(r_ptr) + k);
            if (!w_hit && i_req[w_cand]) begin
                w_hit        = 1'b1;
                o_idx        = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_ptr <= IW'(N - 1);
        else if (i_en && w_hit)
            r_ptr <= o_idx;
    end
endmodule

// File: rtl/bf16_arbiter.sv
// bf16_arbiter: round-robin sharing of one BF16Unit among NUM_REQ requesters
// Grant -> issue register -> compute into per-requester response slot, fixed 2-cycle latency.
module bf16_arbiter
    import bf16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          io_req_valid,
    output logic [NUM_REQ-1:0]          io_req_ready,
    input  logic [OPC_W*NUM_REQ-1:0]    io_req_opc,
    input  logic [BF16_W*NUM_REQ-1:0]   io_req_a,
    input  logic [BF16_W*NUM_REQ-1:0]   io_req_b,
    input  logic [TAG_W*NUM_REQ-1:0]    io_req_tag,
    output logic [NUM_REQ-1:0]          io_rsp_valid,
    input  logic [NUM_REQ-1:0]          io_rsp_ready,
    output logic [BF16_W*NUM_REQ-1:0]   io_rsp_y,
    output logic [TAG_W*NUM_REQ-1:0]    io_rsp_tag,
    output logic [NUM_REQ-1:0]          io_rsp_err
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             r_busy, r_rsp_valid, r_rsp_err;
    logic [NUM_REQ-1:0]             w_rsp_hs, w_elig, w_req, w_gnt, w_wr;
    logic [NUM_REQ-1:0][BF16_W-1:0] r_rsp_y;
    logic [NUM_REQ-1:0][TAG_W-1:0]  r_rsp_tag;
    logic [IW-1:0]                  w_idx, r_iss_idx;
    logic                           r_iss_vld, w_ok;
    logic [OPC_W-1:0]               r_iss_opc;
    logic [BF16_W-1:0]              r_iss_a, r_iss_b, w_y;
    logic [TAG_W-1:0]               r_iss_tag;

    // a slot being drained this cycle may be re-granted immediately
    assign w_rsp_hs = r_rsp_valid & io_rsp_ready;
    assign w_elig   = ~r_busy | w_rsp_hs;
    assign w_req    = io_req_valid & w_elig & {NUM_REQ{reset_n}};
    assign io_req_ready = w_gnt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .i_req   (w_req),
        .i_en    (1'b1),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx)
    );

    BF16Unit u_unit (
        .io_opc (r_iss_opc),
        .io_a   (r_iss_a),
        .io_b   (r_iss_b),
        .io_y   (w_y)
    );

    assign w_ok = r_iss_opc <= OPC_MAX;
    assign w_wr = r_iss_vld ? (NUM_REQ'(1) << r_iss_idx) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_iss_vld   <= 1'b0;
            r_iss_idx   <= '0;
            r_iss_opc   <= '0;
            r_iss_a     <= '0;
            r_iss_b     <= '0;
            r_iss_tag   <= '0;
            r_busy      <= '0;
            r_rsp_valid <= '0;
            r_rsp_y     <= '0;
            r_rsp_tag   <= '0;
            r_rsp_err   <= '0;
        end else begin
            r_iss_vld   <= |w_gnt;
            r_iss_idx   <= w_idx;
            r_iss_opc   <= io_req_opc[int'(w_idx)*OPC_W +: OPC_W];
            r_iss_a     <= io_req_a[int'(w_idx)*BF16_W +: BF16_W];
            r_iss_b     <= io_req_b[int'(w_idx)*BF16_W +: BF16_W];
            r_iss_tag   <= io_req_tag[int'(w_idx)*TAG_W +: TAG_W];
            r_busy      <= (r_busy & ~w_rsp_hs) | w_gnt;
            r_rsp_valid <= (r_rsp_valid & ~w_rsp_hs) | w_wr;
            if (r_iss_vld) begin
                r_rsp_y[r_iss_idx]   <= w_ok ? w_y : '0;
                r_rsp_tag[r_iss_idx] <= r_iss_tag;
                r_rsp_err[r_iss_idx] <= ~w_ok;
            end
        end
    end

    assign io_rsp_valid = r_rsp_valid;
    assign io_rsp_y     = r_rsp_y;
    assign io_rsp_tag   = r_rsp_tag;
    assign io_rsp_err   = r_rsp_err;
endmodule
